// File: rtl/matrix_sub_arbiter_pkg.sv
// Shared types and constants for the matrix subtraction arbiter and the
// fixed-point subtraction unit it fronts.
package matrix_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_WAIT    = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  // Fixed-point format shared with matrix_subtraction_fixed_point
  localparam int FXP_W    = 16;
  localparam int FXP_FRAC = 8;
  localparam int SUB_SIZE = 4;

  // Index width for a requester vector; never collapses to zero bits
  function automatic int req_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_sub_arbiter_if.sv
// Requester/subtraction-unit handshake bundle seen by the arbiter.
interface matrix_sub_arbiter_if import matrix_pkg::*; #(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = req_idx_w(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] req_done;
  logic [NUM_REQ-1:0] req_err;
  logic               sub_start;
  logic               sub_done;
  logic               sub_flush;
  logic               busy;
  logic               timeout_err;

  modport slave (
    input  req, sub_done,
    output grant, grant_idx, req_done, req_err, sub_start, sub_flush, busy, timeout_err
  );

  modport master (
    output req, sub_done,
    input  grant, grant_idx, req_done, req_err, sub_start, sub_flush, busy, timeout_err
  );
endinterface

// File: rtl/matrix_sub_arbiter_picker.sv
// Round-robin priority picker: first set request at or after ptr_i, wrapping.
module rr_priority_picker import matrix_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = req_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  int               k;
  logic [IDX_W-1:0] kk;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    k     = 0;
    kk    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr_i) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      kk = IDX_W'(k);
      if (!vld_o && req_i[kk]) begin
        vld_o     = 1'b1;
        gnt_o[kk] = 1'b1;
        idx_o     = kk;
      end
    end
  end

endmodule

// File: rtl/matrix_sub_arbiter.sv
// Round-robin sequencer sharing one subtraction unit between NUM_REQ stages,
// with a watchdog that flushes a hung unit and reports the owner an error.
module matrix_sub_arbiter import matrix_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  matrix_sub_arbiter_if.slave  bus
);

  localparam int IDX_W = req_idx_w(NUM_REQ);
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, req_done_q, req_err_q;
  logic [IDX_W-1:0]    grant_idx_q, rr_ptr_q;
  logic [WD_W-1:0]     wd_cnt_q;
  logic                sub_start_q, sub_flush_q, busy_q, timeout_err_q, done_q;

  logic [NUM_REQ-1:0]  pk_gnt;
  logic [IDX_W-1:0]    pk_idx;
  logic                pk_vld;
  logic                done_rise, wd_hit, rel_ok, rel_err;

  rr_priority_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i (bus.req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pk_gnt),
    .idx_o (pk_idx),
    .vld_o (pk_vld)
  );

  // done is a sticky level; only a fresh rise means this op finished
  assign done_rise = bus.sub_done & ~done_q;
  assign wd_hit    = (wd_cnt_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    rel_ok  = 1'b0;
    rel_err = 1'b0;
    case (state_q)
      ARB_IDLE:    if (pk_vld) state_d = ARB_ISSUE;
      ARB_ISSUE:   state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (done_rise) begin
          state_d = ARB_RELEASE;
          rel_ok  = 1'b1;
        end else if (wd_hit) begin
          state_d = ARB_RELEASE;
          rel_err = 1'b1;
        end
      end
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      req_done_q    <= '0;
      req_err_q     <= '0;
      sub_start_q   <= 1'b0;
      sub_flush_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      rr_ptr_q      <= '0;
      wd_cnt_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= bus.sub_done;
      busy_q      <= (state_d != ARB_IDLE);
      sub_start_q <= (state_q == ARB_IDLE) && pk_vld;
      req_done_q  <= '0;
      req_err_q   <= '0;
      sub_flush_q <= 1'b0;

      if (state_q == ARB_IDLE && pk_vld) begin
        grant_q     <= pk_gnt;
        grant_idx_q <= pk_idx;
      end

      if (state_q == ARB_ISSUE)
        wd_cnt_q <= '0;
      else if (state_q == ARB_WAIT && !done_rise && !wd_hit)
        wd_cnt_q <= wd_cnt_q + WD_W'(1);

      // grant_q is the one-hot of grant_idx_q, so it doubles as the pulse mask
      if (rel_ok) req_done_q <= grant_q;
      if (rel_err) begin
        req_err_q     <= grant_q;
        sub_flush_q   <= 1'b1;
        timeout_err_q <= 1'b1;
      end

      if (state_q == ARB_RELEASE) begin
        grant_q  <= '0;
        rr_ptr_q <= (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + IDX_W'(1);
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.req_done    = req_done_q;
  assign bus.req_err     = req_err_q;
  assign bus.sub_start   = sub_start_q;
  assign bus.sub_flush   = sub_flush_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_matrix_sub_arbiter.sv
// Randomized scoreboard bench for matrix_sub_arbiter with a behavioural
// subtraction-unit stand-in (normal / hung / done-stuck-high modes).
module tb_matrix_sub_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 64;

  typedef struct {
    int idx;
    bit err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matrix_sub_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  matrix_sub_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  int   m_ptr;
  int   cnt[NUM_REQ];
  bit   early[NUM_REQ];
  int   mode;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Subtraction unit stand-in: mode 0 completes after 1..18 cycles, mode 1 hangs,
  // mode 2 holds done high forever.
  logic done_r;
  int   tmr;
  always @(posedge clk) begin
    if (reset || bus.sub_flush) begin
      done_r <= 1'b0;
      tmr    <= 0;
    end else if (bus.sub_start) begin
      done_r <= 1'b0;
      tmr    <= (mode == 0) ? int'($urandom_range(1, 18)) : 0;
    end else if (tmr > 0) begin
      tmr <= tmr - 1;
      if (tmr == 1) done_r <= 1'b1;
    end
  end
  assign bus.sub_done = (mode == 2) ? 1'b1 : done_r;

  // Monitor: pops the expected owner on every completion/error pulse
  initial begin
    int        cyc, start_cyc, rise_cyc;
    logic      prev_done;
    logic [3:0] pulses, prev_pulse;
    exp_t      e;
    logic [NUM_REQ-1:0] ev;
    cyc = 0; start_cyc = 0; rise_cyc = 0; prev_done = 1'b0; prev_pulse = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.sub_start) start_cyc = cyc;
      if (bus.sub_done === 1'b1 && prev_done === 1'b0 && bus.busy === 1'b1) rise_cyc = cyc;
      prev_done = bus.sub_done;
      if (!reset && bus.grant !== '0)
        chk("grant_onehot", bus.grant, 32'(NUM_REQ'(1) << bus.grant_idx));
      pulses = {bus.sub_start, bus.sub_flush, |bus.req_done, |bus.req_err};
      if (pulses !== '0) chk("pulse_width", pulses & prev_pulse, 0);
      prev_pulse = pulses;
      if (bus.sub_flush === 1'b1) chk("flush_with_err", |bus.req_err, 1);
      if ((|bus.req_done) || (|bus.req_err)) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", {bus.req_done, bus.req_err}, 0);
        end else begin
          e  = sb_q.pop_front();
          ev = NUM_REQ'(1) << e.idx;
          chk("resp_done", bus.req_done, e.err ? '0 : ev);
          chk("resp_err", bus.req_err, e.err ? ev : '0);
          chk("resp_grant", bus.grant, ev);
          if (e.err) begin
            chk("timeout_lat", cyc - start_cyc, TIMEOUT + 1);
            chk("timeout_flush", bus.sub_flush, 1);
            chk("timeout_err_set", bus.timeout_err, 1);
          end else begin
            chk("done_lat", cyc - rise_cyc, 1);
          end
        end
      end
    end
  end

  // Reference: each requester with pending ops is served in round-robin order
  task automatic run_ops(input bit err);
    int c[NUM_REQ];
    int p, k, first, left, n;
    bit found, all_zero;
    left = 0;
    for (int i = 0; i < NUM_REQ; i++) begin c[i] = cnt[i]; left += cnt[i]; end
    p = m_ptr; first = -1;
    while (left > 0) begin
      found = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
        k = (p + j) % NUM_REQ;
        if (!found && c[k] > 0) begin
          found = 1'b1;
          sb_q.push_back('{k, err});
          if (first < 0) first = k;
          c[k]--; left--;
          p = (k + 1) % NUM_REQ;
        end
      end
    end
    m_ptr = p;
    for (int i = 0; i < NUM_REQ; i++) bus.req[i] = (cnt[i] > 0);
    @(negedge clk);
    chk("first_grant", bus.grant, 32'(NUM_REQ'(1) << first));
    chk("first_start", bus.sub_start, 1);
    n = 0;
    forever begin
      all_zero = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_done[i] || bus.req_err[i]) begin
          if (cnt[i] > 0) cnt[i]--;
          if (cnt[i] == 0) bus.req[i] = 1'b0;
        end
        if (early[i] && bus.grant[i]) bus.req[i] = 1'b0;
        if (cnt[i] != 0) all_zero = 1'b0;
      end
      if (all_zero && !bus.busy) break;
      n++;
      if (n > 2000) begin
        chk("run_bound", n, 0);
        break;
      end
      @(negedge clk);
    end
    for (int i = 0; i < NUM_REQ; i++) early[i] = 1'b0;
    chk("queue_drained", sb_q.size(), 0);
  endtask

  initial begin
    int s, w;
    reset = 1'b1; bus.req = '0; mode = 0; m_ptr = 0;
    for (int i = 0; i < NUM_REQ; i++) begin cnt[i] = 0; early[i] = 1'b0; end
    repeat (3) @(negedge clk);
    chk("rst_grant", bus.grant, 0);
    chk("rst_grant_idx", bus.grant_idx, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_req_done", bus.req_done, 0);
    chk("rst_req_err", bus.req_err, 0);
    chk("rst_sub_start", bus.sub_start, 0);
    chk("rst_sub_flush", bus.sub_flush, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    cnt = '{2, 1, 1, 1}; run_ops(0);            // order 0,1,2,3,0
    cnt = '{0, 0, 1, 0}; run_ops(0);            // single requester 2
    cnt = '{1, 1, 0, 0}; run_ops(0);            // wrap from ptr 3
    cnt = '{1, 0, 1, 0}; early[2] = 1'b1; run_ops(0);

    repeat (8) begin
      s = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt[i] = $urandom_range(0, 3);
        early[i] = (cnt[i] == 1) && ($urandom_range(0, 1) == 1);
        s += cnt[i];
      end
      if (s == 0) cnt[$urandom_range(0, NUM_REQ - 1)] = 1;
      run_ops(0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    mode = 2; cnt = '{0, 0, 0, 1}; run_ops(1);  // stale done never completes
    chk("timeout_err_sticky1", bus.timeout_err, 1);
    mode = 1; cnt = '{0, 1, 0, 0}; run_ops(1);  // hung unit
    chk("timeout_err_sticky2", bus.timeout_err, 1);

    // Reset in the middle of a hung op on requester 2
    bus.req[2] = 1'b1;
    w = 0;
    while (bus.sub_start !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    chk("midrst_started", bus.sub_start, 1);
    repeat (5) @(negedge clk);
    chk("midrst_busy_before", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_grant", bus.grant, 0);
    chk("midrst_req_done", bus.req_done, 0);
    chk("midrst_req_err", bus.req_err, 0);
    chk("midrst_timeout_err", bus.timeout_err, 0);
    reset = 1'b0; bus.req = '0; mode = 0; m_ptr = 0;
    repeat (2) @(negedge clk);
    cnt = '{0, 1, 0, 1}; run_ops(0);            // served from ptr 0: 1 then 3

    repeat (3) @(negedge clk);
    chk("final_queue_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
